// File: rtl/array_mac_pipelined.sv
// -----------------------------------------------------------------------------
// array_mac_pipelined
//
// Purpose
//   Pipelined array multiplier with a running accumulator. Each accepted beat
//   computes A*B (signed or unsigned, chosen per beat) by summing DATAWIDTH
//   partial-product rows. The rows are split into NUM_PIPELINE_STAGES+1 groups
//   with a register after every group except the last, which feeds the output
//   register. The product is added into a running accumulator that has a
//   sticky overflow flag. A valid/ready handshake on both sides provides
//   backpressure.
//
// Parameters
//   DATAWIDTH            operand width W (>= 2)
//   NUM_PIPELINE_STAGES  registers between row groups, legal range 0..W-1
//   ACC_WIDTH            accumulator width, must be >= 2*W+1
//   INSTANCE_ID          identifier only; appears in the parameter-check message
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   i_valid      input beat valid
//   i_ready      input beat accepted when i_valid && i_ready
//   i_signed     1: A and B are two's complement, 0: unsigned
//   i_acc_clear  this beat starts a new accumulation from 0
//   A, B         operands, W bits each
//   o_valid      output beat valid
//   o_ready      downstream accepts the output beat
//   Z_final      2*W-bit product of the beat
//   o_acc        accumulator value including this beat
//   o_overflow   sticky accumulator overflow flag
//
// Configuration macro
//   ARRAY_MAC_SATURATE_EN
//     defined:   when an overflow occurs, o_acc saturates. Unsigned beats go
//                to all ones. Signed beats go to max positive or min negative,
//                following the direction of the overflow.
//     undefined: o_acc wraps modulo 2^ACC_WIDTH.
//     In both builds an overflow sets o_overflow.
// -----------------------------------------------------------------------------
module array_mac_pipelined #(
  parameter int DATAWIDTH           = 8,
  parameter int NUM_PIPELINE_STAGES = 2,
  parameter int ACC_WIDTH           = 24,
  parameter int INSTANCE_ID         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic                     i_signed,
  input  logic                     i_acc_clear,
  input  logic [DATAWIDTH-1:0]     A,
  input  logic [DATAWIDTH-1:0]     B,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [2*DATAWIDTH-1:0]   Z_final,
  output logic [ACC_WIDTH-1:0]     o_acc,
  output logic                     o_overflow
);

  localparam int W   = DATAWIDTH;
  localparam int S   = NUM_PIPELINE_STAGES;
  localparam int PW  = 2 * DATAWIDTH;
  localparam int MSB = ACC_WIDTH - 1;

  // Reject illegal configurations at elaboration time.
  if (DATAWIDTH < 2 || NUM_PIPELINE_STAGES < 0 ||
      NUM_PIPELINE_STAGES > DATAWIDTH - 1 || ACC_WIDTH < 2 * DATAWIDTH + 1) begin : g_param_check
    $error("array_mac_pipelined instance %0d: illegal parameter set", INSTANCE_ID);
  end

  // ---------------------------------------------------------------------------
  // Partial-product accumulation over rows [lo, hi).
  //
  // A is extended to 2W bits, sign-extended for signed beats. Row i is
  // (ext(A) << i) when B[i] is set. In a signed beat, the MSB of B carries a
  // weight of -2^(W-1), so the last row is subtracted instead of added. The
  // result is exact modulo 2^(2W), which covers (-2^(W-1))^2.
  // ---------------------------------------------------------------------------
  function automatic logic [PW-1:0] f_rows(
    input logic [W-1:0]  a,
    input logic [W-1:0]  b,
    input logic          sgn,
    input int            lo,
    input int            hi,
    input logic [PW-1:0] psum
  );
    logic [PW-1:0] a_ext;
    logic [PW-1:0] row;
    logic [PW-1:0] sum;
    a_ext = sgn ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sum   = psum;
    for (int i = 0; i < W; i++) begin
      if (i >= lo && i < hi) begin
        row = b[i] ? (a_ext << i) : '0;
        if (sgn && i == W - 1) sum = sum - row;
        else                   sum = sum + row;
      end
    end
    return sum;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake. A single advance signal freezes the whole pipe, the output
  // register included. Bubbles are not collapsed, so the latency stays fixed.
  // ---------------------------------------------------------------------------
  logic w_adv;
  assign w_adv   = !o_valid || o_ready;
  assign i_ready = w_adv;

  // Group inputs. Index g holds what feeds row group g. Index 0 comes from
  // the ports, and index g>0 comes from the register that follows group g-1.
  logic [W-1:0]  w_a        [0:S];
  logic [W-1:0]  w_b        [0:S];
  logic          w_sgn      [0:S];
  logic          w_clr      [0:S];
  logic          w_vld      [0:S];
  logic [PW-1:0] w_psum_in  [0:S];
  logic [PW-1:0] w_psum_out [0:S];

  assign w_a[0]       = A;
  assign w_b[0]       = B;
  assign w_sgn[0]     = i_signed;
  assign w_clr[0]     = i_acc_clear;
  assign w_vld[0]     = i_valid;
  assign w_psum_in[0] = '0;

  // Split the rows as evenly as possible. Because S+1 <= W, every group
  // gets at least one row.
  for (genvar g = 0; g <= S; g++) begin : g_group
    localparam int ROW_LO = (g * W) / (S + 1);
    localparam int ROW_HI = ((g + 1) * W) / (S + 1);
    assign w_psum_out[g] = f_rows(w_a[g], w_b[g], w_sgn[g], ROW_LO, ROW_HI, w_psum_in[g]);
  end

  // Pipeline registers that follow the first S groups.
  for (genvar g = 0; g < S; g++) begin : g_stage
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sgn;
    logic          r_clr;
    logic          r_vld;
    logic [PW-1:0] r_psum;

    // NOTE: sequential state is always assigned with <= so that every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld <= 1'b0;
      end else if (w_adv) begin
        r_vld <= w_vld[g];
      end
    end

    // NOTE: the datapath registers have no reset. Only the valid bits
    // qualify them, so a stale payload behind a cleared valid is harmless.
    always_ff @(posedge clk) begin
      if (w_adv) begin
        r_a    <= w_a[g];
        r_b    <= w_b[g];
        r_sgn  <= w_sgn[g];
        r_clr  <= w_clr[g];
        r_psum <= w_psum_out[g];
      end
    end

    assign w_a[g+1]       = r_a;
    assign w_b[g+1]       = r_b;
    assign w_sgn[g+1]     = r_sgn;
    assign w_clr[g+1]     = r_clr;
    assign w_vld[g+1]     = r_vld;
    assign w_psum_in[g+1] = r_psum;
  end

  // ---------------------------------------------------------------------------
  // Accumulate and detect overflow for the beat that is entering the output
  // register.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        w_prod;
  logic [ACC_WIDTH-1:0] w_base;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_carry;
  logic                 w_ovf;
  logic                 w_ovf_next;

  assign w_prod = w_psum_out[S];

  always_comb begin
    // NOTE: every output gets a default value first, so no path through
    // this block can leave a value unassigned and infer a latch.
    w_base     = w_clr[S] ? '0 : o_acc;
    w_ext      = w_sgn[S] ? {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod}
                          : {{(ACC_WIDTH-PW){1'b0}}, w_prod};
    {w_carry, w_sum} = {1'b0, w_base} + {1'b0, w_ext};
    w_ovf      = 1'b0;
    w_acc_next = w_sum;

    if (w_sgn[S]) begin
      // Two's-complement overflow: both addends have the same sign and the
      // sum has the other sign.
      w_ovf = (w_base[MSB] == w_ext[MSB]) && (w_sum[MSB] != w_base[MSB]);
    end else begin
      w_ovf = w_carry;
    end

`ifdef ARRAY_MAC_SATURATE_EN
    if (w_ovf) begin
      if (!w_sgn[S])        w_acc_next = '1;
      else if (w_base[MSB]) w_acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      else                  w_acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
`endif

    // A clear beat starts from 0 and cannot overflow, because ACC_WIDTH > 2W.
    w_ovf_next = (w_clr[S] ? 1'b0 : o_overflow) | w_ovf;
  end

  // Output register. The product, accumulator and flag load only with a
  // valid beat, so they hold across bubbles as well as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      Z_final    <= '0;
      o_acc      <= '0;
      o_overflow <= 1'b0;
    end else if (w_adv) begin
      o_valid <= w_vld[S];
      if (w_vld[S]) begin
        Z_final    <= w_prod;
        o_acc      <= w_acc_next;
        o_overflow <= w_ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_array_mac_pipelined.sv
// -----------------------------------------------------------------------------
// tb_array_mac_pipelined
//
// Directed testbench for array_mac_pipelined at W=8, two pipeline stages and
// ACC_WIDTH=24. The bench drives inputs on the falling clock edge and samples
// outputs 1 ns later, away from the rising edge. Each scenario task makes its
// own comparisons against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_array_mac_pipelined;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic          i_signed;
  logic          i_acc_clear;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          o_valid;
  logic          o_ready;
  logic [2*W-1:0] Z_final;
  logic [AW-1:0] o_acc;
  logic          o_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  array_mac_pipelined #(
    .DATAWIDTH          (W),
    .NUM_PIPELINE_STAGES(S),
    .ACC_WIDTH          (AW),
    .INSTANCE_ID        (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .i_signed   (i_signed),
    .i_acc_clear(i_acc_clear),
    .A          (A),
    .B          (B),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .Z_final    (Z_final),
    .o_acc      (o_acc),
    .o_overflow (o_overflow)
  );

  // Beats queued for run_stream, and the outputs it captured.
  logic [W-1:0]   q_a [$];
  logic [W-1:0]   q_b [$];
  logic           q_s [$];
  logic           q_c [$];
  logic [2*W-1:0] cap_z   [$];
  logic [AW-1:0]  cap_acc [$];
  logic           cap_ovf [$];

  task automatic add_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c);
    q_a.push_back(a);
    q_b.push_back(b);
    q_s.push_back(s);
    q_c.push_back(c);
  endtask

  // Sends all queued beats back to back with o_ready=1 and captures every
  // valid output. The cycle budget is bounded by the queue length.
  task automatic run_stream();
    int n;
    int sent;
    n    = q_a.size();
    sent = 0;
    cap_z.delete();
    cap_acc.delete();
    cap_ovf.delete();
    for (int cyc = 0; cyc < n + S + 6; cyc++) begin
      @(negedge clk);
      o_ready = 1'b1;
      if (sent < n) begin
        i_valid     = 1'b1;
        A           = q_a[sent];
        B           = q_b[sent];
        i_signed    = q_s[sent];
        i_acc_clear = q_c[sent];
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (i_valid && i_ready) sent++;
      if (o_valid) begin
        cap_z.push_back(Z_final);
        cap_acc.push_back(o_acc);
        cap_ovf.push_back(o_overflow);
      end
    end
    i_valid = 1'b0;
    q_a.delete();
    q_b.delete();
    q_s.delete();
    q_c.delete();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
    checks++;
    if (Z_final !== 16'h0) begin errors++; $display("FAIL reset_z: got %h expected 0000", Z_final); end
    checks++;
    if (o_acc !== 24'h0) begin errors++; $display("FAIL reset_acc: got %h expected 000000", o_acc); end
    checks++;
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", o_overflow); end
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b expected 1", i_ready); end
  endtask

  // Unsigned 255*255 with clear: the output must appear exactly 3 cycles later.
  task automatic test_latency_unsigned();
    @(negedge clk);
    o_ready = 1'b1; i_valid = 1'b1; A = 8'hFF; B = 8'hFF; i_signed = 1'b0; i_acc_clear = 1'b1;
    #1;
    checks++;
    if (i_ready !== 1'b1) begin errors++; $display("FAIL lat_accept: got i_ready=%b expected 1", i_ready); end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      i_valid = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("FAIL lat_early_%0d: got o_valid=%b expected 0", k, o_valid); end
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL lat_arrive: got o_valid=%b expected 1", o_valid); end
    checks++;
    if (Z_final !== 16'hFE01) begin errors++; $display("FAIL lat_z: got %h expected fe01", Z_final); end
    checks++;
    if (o_acc !== 24'h00FE01) begin errors++; $display("FAIL lat_acc: got %h expected 00fe01", o_acc); end
    @(negedge clk);
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_acc !== 24'h00FE01) begin
      errors++;
      $display("FAIL lat_bubble: got o_valid=%b acc=%h expected 0 00fe01", o_valid, o_acc);
    end
  endtask

  task automatic test_signed();
    logic [15:0] exp_z   [3] = '{16'h4000, 16'hFFFF, 16'hFFF1};
    logic [23:0] exp_acc [3] = '{24'h004000, 24'h003FFF, 24'hFFFFF1};
    add_beat(8'h80, 8'h80, 1'b1, 1'b1);   // -128 * -128
    add_beat(8'hFF, 8'h01, 1'b1, 1'b0);   // -1 * 1
    add_beat(8'hFD, 8'h05, 1'b1, 1'b1);   // -3 * 5, new accumulation
    run_stream();
    checks++;
    if (cap_z.size() != 3) begin errors++; $display("FAIL signed_count: got %0d expected 3", cap_z.size()); end
    for (int k = 0; k < 3 && k < cap_z.size(); k++) begin
      checks++;
      if (cap_z[k] !== exp_z[k] || cap_acc[k] !== exp_acc[k] || cap_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL signed_beat%0d: got z=%h acc=%h ovf=%b expected z=%h acc=%h ovf=0",
                 k, cap_z[k], cap_acc[k], cap_ovf[k], exp_z[k], exp_acc[k]);
      end
    end
  endtask

  task automatic test_clear();
    logic [15:0] exp_z   [3] = '{16'd12, 16'd30, 16'd4};
    logic [23:0] exp_acc [3] = '{24'd12, 24'd42, 24'd4};
    add_beat(8'd3, 8'd4, 1'b0, 1'b1);
    add_beat(8'd5, 8'd6, 1'b0, 1'b0);
    add_beat(8'd2, 8'd2, 1'b0, 1'b1);
    run_stream();
    checks++;
    if (cap_z.size() != 3) begin errors++; $display("FAIL clear_count: got %0d expected 3", cap_z.size()); end
    for (int k = 0; k < 3 && k < cap_z.size(); k++) begin
      checks++;
      if (cap_z[k] !== exp_z[k] || cap_acc[k] !== exp_acc[k] || cap_ovf[k] !== 1'b0) begin
        errors++;
        $display("FAIL clear_beat%0d: got z=%0d acc=%0d ovf=%b expected z=%0d acc=%0d ovf=0",
                 k, cap_z[k], cap_acc[k], cap_ovf[k], exp_z[k], exp_acc[k]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] exp_last;
`ifdef ARRAY_MAC_SATURATE_EN
    exp_last = 24'hFFFFFF;
`else
    exp_last = 24'd64259;
`endif
    for (int k = 0; k < 259; k++) add_beat(8'hFF, 8'hFF, 1'b0, k == 0);
    add_beat(8'd1, 8'd1, 1'b0, 1'b1);
    run_stream();
    checks++;
    if (cap_acc.size() != 260) begin
      errors++;
      $display("FAIL ovf_count: got %0d expected 260", cap_acc.size());
    end else begin
      for (int k = 0; k < 258; k++) begin
        checks++;
        if (cap_acc[k] !== 24'((k + 1) * 65025) || cap_ovf[k] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_running%0d: got acc=%0d ovf=%b expected acc=%0d ovf=0",
                   k, cap_acc[k], cap_ovf[k], (k + 1) * 65025);
        end
      end
      checks++;
      if (cap_acc[257] !== 24'd16776450) begin errors++; $display("FAIL ovf_beat258: got %0d expected 16776450", cap_acc[257]); end
      checks++;
      if (cap_acc[258] !== exp_last) begin errors++; $display("FAIL ovf_beat259_acc: got %h expected %h", cap_acc[258], exp_last); end
      checks++;
      if (cap_ovf[258] !== 1'b1) begin errors++; $display("FAIL ovf_beat259_flag: got %b expected 1", cap_ovf[258]); end
      checks++;
      if (cap_ovf[259] !== 1'b0 || cap_acc[259] !== 24'd1) begin
        errors++;
        $display("FAIL ovf_clear: got ovf=%b acc=%0d expected ovf=0 acc=1", cap_ovf[259], cap_acc[259]);
      end
    end
  endtask

  // Six back-to-back beats. o_ready is held low for 5 cycles after the first
  // output is accepted.
  task automatic test_back_to_back();
    logic [15:0] exp_z   [6] = '{16'd2, 16'd12, 16'd30, 16'd56, 16'd90, 16'd132};
    logic [23:0] exp_acc [6] = '{24'd2, 24'd14, 24'd44, 24'd100, 24'd190, 24'd322};
    int in_idx;
    int out_idx;
    int stall_left;
    int stall_seen;
    logic have_held;
    logic [15:0] held_z;
    logic [23:0] held_acc;
    in_idx = 0; out_idx = 0; stall_left = 5; stall_seen = 0; have_held = 1'b0;
    held_z = '0; held_acc = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (out_idx >= 1 && stall_left > 0) begin
        o_ready = 1'b0;
        stall_left--;
      end else begin
        o_ready = 1'b1;
      end
      if (in_idx < 6) begin
        i_valid = 1'b1; A = 8'(2 * in_idx + 1); B = 8'(2 * in_idx + 2);
        i_signed = 1'b0; i_acc_clear = (in_idx == 0);
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (o_valid && !o_ready) begin
        stall_seen++;
        checks++;
        if (i_ready !== 1'b0) begin errors++; $display("FAIL b2b_i_ready: got %b expected 0", i_ready); end
        if (have_held) begin
          checks++;
          if (Z_final !== held_z || o_acc !== held_acc) begin
            errors++;
            $display("FAIL b2b_hold: got z=%0d acc=%0d expected z=%0d acc=%0d", Z_final, o_acc, held_z, held_acc);
          end
        end
        held_z = Z_final; held_acc = o_acc; have_held = 1'b1;
      end
      if (i_valid && i_ready) in_idx++;
      if (o_valid && o_ready) begin
        checks++;
        if (out_idx >= 6) begin
          errors++;
          $display("FAIL b2b_extra: got extra output z=%0d expected none", Z_final);
        end else if (Z_final !== exp_z[out_idx] || o_acc !== exp_acc[out_idx]) begin
          errors++;
          $display("FAIL b2b_out%0d: got z=%0d acc=%0d expected z=%0d acc=%0d",
                   out_idx, Z_final, o_acc, exp_z[out_idx], exp_acc[out_idx]);
        end
        out_idx++;
      end
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    checks++;
    if (out_idx != 6 || in_idx != 6) begin
      errors++;
      $display("FAIL b2b_count: got in=%0d out=%0d expected 6 6", in_idx, out_idx);
    end
    checks++;
    if (stall_seen != 5) begin errors++; $display("FAIL b2b_stall_cycles: got %0d expected 5", stall_seen); end
  endtask

  // Reset with three beats in flight: all outputs clear and no stale beat follows.
  task automatic test_reset_midstream();
    int stale;
    o_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_valid = 1'b1; A = 8'(7 + k); B = 8'd9; i_signed = 1'b0; i_acc_clear = (k == 0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_acc !== 24'd63) begin
      errors++;
      $display("FAIL mid_pre: got o_valid=%b acc=%0d expected 1 63", o_valid, o_acc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_acc !== 24'd0 || o_overflow !== 1'b0 || Z_final !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b acc=%0d ovf=%b z=%0d expected 0 0 0 0", o_valid, o_acc, o_overflow, Z_final);
    end
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (o_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL mid_stale: got %0d stale beats expected 0", stale); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1; i_valid = 1'b0; A = '0; B = '0;
    i_signed = 1'b0; i_acc_clear = 1'b0; o_ready = 1'b1;
    test_reset();
    test_latency_unsigned();
    test_signed();
    test_clear();
    test_back_to_back();
    test_overflow();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
